// File: rtl/iddr_pkg.sv
// iddr_pkg: edge-mode encodings and parameter checks shared by the DDR capture blocks
package iddr_pkg;
  localparam logic [1:0] MODE_OPP  = 2'd0;
  localparam logic [1:0] MODE_SAME = 2'd1;
  localparam logic [1:0] MODE_PIPE = 2'd2;
  // unknown mode strings fall back to the pipelined mode
  function automatic logic [1:0] mode_enc(input string s);
    return s == "OPPOSITE_EDGE" ? MODE_OPP : s == "SAME_EDGE" ? MODE_SAME : MODE_PIPE;
  endfunction
  function automatic logic ratio_ok(input int r);
    return r >= 2 && r <= 8 && r % 2 == 0;
  endfunction
endpackage

// File: rtl/iddr_lane.sv
// iddr_lane: one lane's rise/fall capture, negedge-to-posedge retiming and Q1/Q2 mode mux
module iddr_lane
  import iddr_pkg::*;
#(
  parameter logic [1:0] MODE    = MODE_PIPE,
  parameter logic       INIT_Q1 = 1'b0,
  parameter logic       INIT_Q2 = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce_i,
  input  logic d_i,
  output logic q1_o,
  output logic q2_o,
  output logic rise_o,
  output logic fall_o
);
  logic rise_q, rise_dly_q, fall_q, fall_ret_q;
  // falling-edge sample, also cleared on the falling edge while reset is held
  always_ff @(negedge clk)
    if (rst) fall_q <= INIT_Q2;
    else if (ce_i) fall_q <= d_i;
  // rising-edge sample, its one-cycle delay, and the fall sample moved onto the rising edge
  always_ff @(posedge clk)
    if (rst) begin
      rise_q     <= INIT_Q1;
      rise_dly_q <= INIT_Q1;
      fall_ret_q <= INIT_Q2;
    end else if (ce_i) begin
      rise_q     <= d_i;
      rise_dly_q <= rise_q;
      fall_ret_q <= fall_q;
    end
  // edge-mode select; the pipelined mode pairs the delayed rise with the retimed fall
  always_comb begin
    q1_o = MODE == MODE_PIPE ? rise_dly_q : rise_q;
    q2_o = MODE == MODE_OPP ? fall_q : fall_ret_q;
  end
  // the delayed rise and retimed fall form the (r_n, f_n) pair seen two edges later
  assign rise_o = rise_dly_q;
  assign fall_o = fall_ret_q;
endmodule

// File: rtl/iddr_deser.sv
// iddr_deser: multi-lane input DDR capture with a shared word deserializer and bitslip
module iddr_deser
  import iddr_pkg::*;
#(
  parameter int    WIDTH        = 1,
  parameter int    RATIO        = 4,
  parameter string DDR_CLK_EDGE = "SAME_EDGE_PIPELINED",
  parameter logic  INIT_Q1      = 1'b0,
  parameter logic  INIT_Q2      = 1'b0
) (
  input  logic                   C,
  input  logic                   R,
  input  logic                   CE,
  input  logic [WIDTH-1:0]       D,
  input  logic                   BITSLIP,
  output logic [WIDTH-1:0]       Q1,
  output logic [WIDTH-1:0]       Q2,
  output logic [WIDTH*RATIO-1:0] DOUT,
  output logic                   DVALID
);
  localparam logic [1:0] MODE = mode_enc(DDR_CLK_EDGE);
  localparam logic [1:0] LAST = 2'(RATIO / 2 - 1);
  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("iddr_deser: RATIO must be even and within 2..8");
  end
  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0][RATIO:0] hist_q, hist_d;
  logic [WIDTH*RATIO-1:0] word, dout_q;
  logic [1:0] cnt_q, cnt_d, v_q;
  logic off_q, pend_q, rdy_q, dvalid_q;
  logic shift, slip, hold, done;
  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    iddr_lane #(.MODE(MODE), .INIT_Q1(INIT_Q1), .INIT_Q2(INIT_Q2)) u_lane (
      .clk(C), .rst(R), .ce_i(CE), .d_i(D[l]),
      .q1_o(Q1[l]), .q2_o(Q2[l]), .rise_o(rise[l]), .fall_o(fall[l])
    );
  end
  // pair shifting, slip-adjusted pair counting and word extraction at the current offset
  always_comb begin
    shift  = v_q[1];
    slip   = BITSLIP && !pend_q;
    hold   = slip && !off_q;
    done   = shift && !hold && cnt_q == LAST;
    cnt_d  = shift && !hold ? (done ? 2'd0 : cnt_q + 2'd1) : cnt_q;
    hist_d = hist_q;
    word   = '0;
    for (int l = 0; l < WIDTH; l++) begin
      hist_d[l] = shift ? {hist_q[l][RATIO-2:0], rise[l], fall[l]} : hist_q[l];
      word[l*RATIO +: RATIO] = off_q ? hist_q[l][RATIO:1] : hist_q[l][RATIO-1:0];
    end
  end
  // shared deserializer state; v_q marks when the capture pipeline carries post-reset pairs
  always_ff @(posedge C)
    if (R) begin
      cnt_q    <= '0;
      v_q      <= '0;
      off_q    <= 1'b0;
      pend_q   <= 1'b0;
      rdy_q    <= 1'b0;
      hist_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else if (CE) begin
      cnt_q    <= cnt_d;
      v_q      <= {v_q[0], 1'b1};
      off_q    <= off_q ^ slip;
      pend_q   <= slip;
      rdy_q    <= done;
      hist_q   <= hist_d;
      dvalid_q <= rdy_q;
      if (rdy_q) dout_q <= word;
    end else dvalid_q <= 1'b0;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
endmodule
